nh_lcd_bus_engine: RTL
======================

# nh_lcd_bus_engine

Parametrised command/data engine for the NH LCD parallel bus in the wishbone `wb_nh_lcd` slave. It turns single-cycle write/read strobes from the controller into a fully timed bus cycle: setup, strobe and hold phases, each sized at run time. It drives register-select (command vs. pixel data), direction, write/read strobes and the data bus, and captures read data. It sits between the LCD controller FSM and the pad-level tri-state logic.

## Interface
- `DATA_WIDTH`, 8: bus width in bits; 8 or 16.
- `CNT_WIDTH`, 4: width of each phase-length input.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `debug` out 32: `{20'h0, cnt[7:0], state[3:0]}` (cnt zero-extended or truncated to 8 bits).
- `i_enable` in 1: strobes are ignored while low.
- `i_cmd_write_stb` in 1: one-cycle request for a bus write.
- `i_cmd_read_stb` in 1: one-cycle request for a bus read.
- `i_cmd_is_data` in 1: 1 for a data/pixel cycle, 0 for a command cycle. Sampled at accept.
- `i_cmd_data` in DATA_WIDTH: write payload. Sampled at accept.
- `i_setup_cycles` in CNT_WIDTH: S, address-setup cycles; 0 is legal.
- `i_strobe_cycles` in CNT_WIDTH: P, strobe width; 0 is treated as 1.
- `i_hold_cycles` in CNT_WIDTH: H, hold cycles; 0 is legal.
- `o_cmd_data` out DATA_WIDTH: last read value.
- `o_cmd_en_write` out 1: 1 means the pad drives `o_data_out`.
- `o_rs` out 1: register select, equal to the latched `i_cmd_is_data`.
- `o_busy` out 1: transaction in progress.
- `o_cmd_finished` out 1: one-cycle completion pulse.
- `o_write` out 1: active-high write strobe.
- `o_read` out 1: active-high read strobe.
- `o_data_out` out DATA_WIDTH: write data.
- `i_data_in` in DATA_WIDTH: bus read data.

## Operation
- Reset value of every output is 0, and state is IDLE.
- States:
  - IDLE: accepts a strobe.
  - SETUP: addresses and direction are driven; no strobe.
  - STROBE: `o_write` or `o_read` is high.
  - HOLD: strobes are low; data and rs are held.
  - FINISHED: `o_cmd_finished` is 1; returns to IDLE.
- Accept condition: state is IDLE and `i_enable` is high and either strobe is high.
  - If both strobes are high, the write wins and the read is dropped.
  - Strobes arriving in any state other than IDLE are dropped; there is no queue.
- On accept, the block latches S, P (with 0 forced to 1), H, `i_cmd_is_data`, direction and `i_cmd_data`.
  - It sets `o_busy`, `o_rs` and `o_cmd_en_write` (1 for a write, 0 for a read), and loads `o_data_out` for a write.
  - Next state is SETUP if S>0, otherwise STROBE.
- Transitions:
  - SETUP → STROBE after S cycles.
  - STROBE → HOLD after P cycles, or → FINISHED if H=0.
  - HOLD → FINISHED after H cycles.
  - A single down-counter is reloaded at every phase entry.
- Reads: `i_data_in` is registered into `o_cmd_data` on the clock edge that ends the last STROBE cycle. `o_cmd_data` is unchanged by writes.
- FINISHED: `o_cmd_finished`=1 and `o_busy`=1.
  - On the next cycle, all of these return to 0: `o_busy`, `o_write`, `o_read`, `o_cmd_en_write`.
  - `o_rs` and `o_data_out` keep their last values.
- Dropping `i_enable` mid-transaction does not abort it; the transaction completes normally.
- Changing any phase-length input mid-transaction has no effect, because the values were latched at accept.
- Asserting `rst_n` low at any point immediately forces all outputs to 0 and state to IDLE; no finished pulse is issued.

## Timing
- A strobe is sampled at edge k. Outputs are registered, so in the cycles that follow:
  - SETUP occupies cycles k+1 … k+S.
  - `o_write`/`o_read` are high for cycles k+1+S … k+S+P.
  - HOLD occupies cycles k+S+P+1 … k+S+P+H.
  - `o_cmd_finished` is high in cycle k+1+S+P+H.
- Minimum transaction (S=0, P≤1, H=0): strobe in cycle k+1, finished in cycle k+2.
- Next accept is possible at the edge ending cycle k+2+S+P+H, so back-to-back throughput is S+P+H+2 cycles.
- Direction and rs are stable from cycle k+1 until after FINISHED. `o_data_out` does not change while `o_write` is high.
- Read data is valid on `o_cmd_data` in the finished cycle and stays valid until the next read completes.

## Structure
- Shared package `nh_lcd_pkg` holds:
  - state encodings (4-bit: IDLE=0, SETUP=1, STROBE=2, HOLD=3, FINISHED=4);
  - the default `DATA_WIDTH` and `CNT_WIDTH`;
  - the debug field offsets.
- One sub-module, `nh_lcd_phase_counter`: a loadable CNT_WIDTH down-counter with a `load`/`value` input and a `done` flag (value==1 or loaded 0). The FSM stays in the top level.

## Test plan
- Write, S=1, P=2, H=1, data=0xA5, is_data=0, strobe at edge 0:
  - `o_write` high in cycles 2–3;
  - `o_data_out`=0xA5 and `o_rs`=0 from cycle 1;
  - finished pulse in cycle 5 only.
- Read, S=0, P=0, H=0, `i_data_in`=0x3C:
  - `o_read` high in cycle 1 only;
  - `o_cmd_en_write`=0 throughout;
  - `o_cmd_data`=0x3C with finished in cycle 2.
- Simultaneous write and read strobes, data=0x11: a write cycle occurs, `o_read` never rises, and exactly one finished pulse is issued.
- Strobes with `i_enable`=0, or during `o_busy`=1: no bus activity, no extra finished pulse. Deasserting `i_enable` mid-transaction: the transaction still completes.
- `rst_n` pulsed low during STROBE (S=2, P=8): all outputs go to 0 asynchronously, and no finished pulse is issued. A new write after release runs with correct timing.
- DATA_WIDTH=16, write 0xBEEF, then read 0x1234 back-to-back: `o_data_out`=0xBEEF, `o_cmd_data`=0x1234, and the second accept occurs exactly S+P+H+2 cycles after the first.

Source files
------------

// File: rtl/nh_lcd_pkg.sv
// Shared definitions for the NH LCD parallel bus engine: state encodings,
// default widths and debug word layout.
package nh_lcd_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_CNT_WIDTH  = 4;

  localparam int unsigned DBG_STATE_LSB = 0;
  localparam int unsigned DBG_STATE_W   = 4;
  localparam int unsigned DBG_CNT_LSB   = 4;
  localparam int unsigned DBG_CNT_W     = 8;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SETUP    = 4'd1,
    ST_STROBE   = 4'd2,
    ST_HOLD     = 4'd3,
    ST_FINISHED = 4'd4
  } lcd_state_e;

endpackage

// File: rtl/nh_lcd_phase_counter.sv
// Loadable down-counter sizing one bus phase; done marks the last cycle of
// a phase (count 1) or a zero-length load.
module nh_lcd_phase_counter
  import nh_lcd_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] value,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0) || (cnt == CNT_WIDTH'(1));

endmodule

// File: rtl/nh_lcd_bus_engine.sv
// Timed command/data bus cycle generator for the NH LCD parallel interface:
// setup, strobe and hold phases sized at accept time, with read capture.
module nh_lcd_bus_engine
  import nh_lcd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [31:0]           debug,
  input  logic                  i_enable,
  input  logic                  i_cmd_write_stb,
  input  logic                  i_cmd_read_stb,
  input  logic                  i_cmd_is_data,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  input  logic [CNT_WIDTH-1:0]  i_setup_cycles,
  input  logic [CNT_WIDTH-1:0]  i_strobe_cycles,
  input  logic [CNT_WIDTH-1:0]  i_hold_cycles,
  output logic [DATA_WIDTH-1:0] o_cmd_data,
  output logic                  o_cmd_en_write,
  output logic                  o_rs,
  output logic                  o_busy,
  output logic                  o_cmd_finished,
  output logic                  o_write,
  output logic                  o_read,
  output logic [DATA_WIDTH-1:0] o_data_out,
  input  logic [DATA_WIDTH-1:0] i_data_in
);

  lcd_state_e           state, state_nxt;
  logic [CNT_WIDTH-1:0] strobe_len, hold_len;
  logic [CNT_WIDTH-1:0] strobe_eff;
  logic [CNT_WIDTH-1:0] cnt, cnt_value;
  logic [7:0]           cnt8;
  logic                 cnt_load, cnt_done;
  logic                 accept, dir_write;

  assign accept     = (state == ST_IDLE) && i_enable && (i_cmd_write_stb || i_cmd_read_stb);
  assign strobe_eff = (i_strobe_cycles == '0) ? CNT_WIDTH'(1) : i_strobe_cycles;
  // Direction comes from the live strobe on the accept edge, then from the latch.
  assign dir_write  = (state == ST_IDLE) ? i_cmd_write_stb : o_cmd_en_write;

  nh_lcd_phase_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_phase_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .value (cnt_value),
    .cnt   (cnt),
    .done  (cnt_done)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
          if (i_setup_cycles != '0) begin
            state_nxt = ST_SETUP;
            cnt_value = i_setup_cycles;
          end else begin
            state_nxt = ST_STROBE;
            cnt_value = strobe_eff;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          state_nxt = ST_STROBE;
          cnt_load  = 1'b1;
          cnt_value = strobe_len;
        end
      end
      ST_STROBE: begin
        if (cnt_done) begin
          if (hold_len != '0) begin
            state_nxt = ST_HOLD;
            cnt_load  = 1'b1;
            cnt_value = hold_len;
          end else begin
            state_nxt = ST_FINISHED;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          state_nxt = ST_FINISHED;
        end
      end
      ST_FINISHED: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      strobe_len     <= '0;
      hold_len       <= '0;
      o_cmd_data     <= '0;
      o_cmd_en_write <= 1'b0;
      o_rs           <= 1'b0;
      o_busy         <= 1'b0;
      o_cmd_finished <= 1'b0;
      o_write        <= 1'b0;
      o_read         <= 1'b0;
      o_data_out     <= '0;
    end else begin
      state          <= state_nxt;
      o_busy         <= (state_nxt != ST_IDLE);
      o_cmd_finished <= (state_nxt == ST_FINISHED);
      o_write        <= (state_nxt == ST_STROBE) && dir_write;
      o_read         <= (state_nxt == ST_STROBE) && !dir_write;
      if (accept) begin
        strobe_len     <= strobe_eff;
        hold_len       <= i_hold_cycles;
        o_rs           <= i_cmd_is_data;
        o_cmd_en_write <= i_cmd_write_stb;
        if (i_cmd_write_stb) begin
          o_data_out <= i_cmd_data;
        end
      end else if (state_nxt == ST_IDLE) begin
        o_cmd_en_write <= 1'b0;
      end
      if ((state == ST_STROBE) && cnt_done && !o_cmd_en_write) begin
        o_cmd_data <= i_data_in;
      end
    end
  end

  generate
    if (CNT_WIDTH >= 8) begin : g_cnt_trunc
      assign cnt8 = cnt[7:0];
    end else begin : g_cnt_ext
      assign cnt8 = {{(8 - CNT_WIDTH){1'b0}}, cnt};
    end
  endgenerate

  always_comb begin
    debug = '0;
    debug[DBG_STATE_LSB +: DBG_STATE_W] = state;
    debug[DBG_CNT_LSB +: DBG_CNT_W]     = cnt8;
  end

endmodule
